// File: rtl/sync_fifo_pro.sv
// rtl/sync_fifo_pro.sv - Single-clock FIFO with selectable registered or FWFT read and runtime thresholds.
// Optional per-word even parity is enabled by defining SYNC_FIFO_PARITY_EN.
module sync_fifo_pro #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int RDATA_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
`ifdef SYNC_FIFO_PARITY_EN
    input  logic                  err_inject,
    output logic                  parity_err,
`endif
    output logic                  overflow,
    output logic                  underflow
);

`ifdef SYNC_FIFO_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    logic [MEM_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [MEM_WIDTH-1:0]  wr_word;
    logic [MEM_WIDTH-1:0]  rd_word;
    logic [DATA_WIDTH-1:0] rd_word_data;

    // A full FIFO still takes a write when the same edge frees a slot.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {(^wr_data) ^ err_inject, wr_data};
`else
    assign wr_word = wr_data;
`endif
    assign rd_word      = mem[rd_ptr];
    assign rd_word_data = rd_word[DATA_WIDTH-1:0];

    assign data_count   = count;
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= afull_thresh);
    assign almost_empty = (count <= aempty_thresh);

    // Storage is deliberately not reset; clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
            overflow  <= wr_en && !wr_accept;
            underflow <= rd_en && !rd_accept;
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_accept && (^rd_word);
        end
    end
`endif

    generate
        if (RDATA_MODE == 0) begin : g_registered
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                    if (rd_accept) begin
                        rd_data_q <= rd_word_data;
                    end
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            // Head word is always presented; a read simply advances the pointer.
            assign rd_data  = rd_word_data;
            assign rd_valid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_pro.sv
// tb/tb_sync_fifo_pro.sv - Directed self-checking bench for sync_fifo_pro (registered and FWFT instances).
module tb_sync_fifo_pro;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [4:0] afull_thresh;
    logic [4:0] aempty_thresh;
    logic       err_inject;

    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic       full0, empty0, afull0, aempty0, ovf0, unf0;
    logic       full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [4:0] count0, count1;
    logic       perr0, perr1;

    int checks;
    int errors;

    sync_fifo_pro #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4), .RDATA_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .full(full0), .empty(empty0), .almost_full(afull0), .almost_empty(aempty0),
        .data_count(count0),
`ifdef SYNC_FIFO_PARITY_EN
        .err_inject(err_inject), .parity_err(perr0),
`endif
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_pro #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4), .RDATA_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .full(full1), .empty(empty1), .almost_full(afull1), .almost_empty(aempty1),
        .data_count(count1),
`ifdef SYNC_FIFO_PARITY_EN
        .err_inject(err_inject), .parity_err(perr1),
`endif
        .overflow(ovf1), .underflow(unf1)
    );

`ifndef SYNC_FIFO_PARITY_EN
    assign perr0 = 1'b0;
    assign perr1 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty0); end
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full0); end
        checks++; if (aempty0 !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", aempty0); end
        checks++; if (afull0 !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", afull0); end
        checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count0); end
        checks++; if ({ovf0, unf0, rd_valid0, perr0} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {ovf0, unf0, rd_valid0, perr0}); end
        checks++; if (rd_data0 !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data0); end
        checks++; if (rd_valid1 !== 1'b0) begin errors++; $display("FAIL reset_fwft_valid got %b exp 0", rd_valid1); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic_rw();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'hA5 + 8'(i);
            cycle();
        end
        wr_en = 1'b0;
        checks++; if (count0 !== 5'd4) begin errors++; $display("FAIL basic_count got %0d exp 4", count0); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'hA5 + 8'(i);
            checks++; if (rd_data1 !== exp || rd_valid1 !== 1'b1) begin errors++; $display("FAIL basic_fwft_head got %h/%b exp %h/1", rd_data1, rd_valid1, exp); end
            rd_en = 1'b1;
            cycle();
            checks++; if (rd_data0 !== exp || rd_valid0 !== 1'b1) begin errors++; $display("FAIL basic_read got %h/%b exp %h/1", rd_data0, rd_valid0, exp); end
        end
        rd_en = 1'b0;
        cycle();
        checks++; if (rd_valid0 !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", rd_valid0); end
        checks++; if (empty0 !== 1'b1 || rd_data0 !== 8'hA8) begin errors++; $display("FAIL basic_empty_hold got %b/%h exp 1/a8", empty0, rd_data0); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            cycle();
            if (i == 15) begin
                checks++; if (full0 !== 1'b1 || count0 !== 5'd16) begin errors++; $display("FAIL ovf_full16 got %b/%0d exp 1/16", full0, count0); end
                checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf0); end
            end
        end
        wr_en = 1'b0;
        checks++; if (ovf0 !== 1'b1 || count0 !== 5'd16) begin errors++; $display("FAIL ovf_pulse got %b/%0d exp 1/16", ovf0, count0); end
        cycle();
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b exp 0", ovf0); end
    endtask

    task automatic test_full_rdwr();
        logic [7:0] q[$];
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h40 + 8'(i);
            q.push_back(wr_data);
            exp = q.pop_front();
            cycle();
            checks++; if (full0 !== 1'b1 || ovf0 !== 1'b0) begin errors++; $display("FAIL rdwr_full got full=%b ovf=%b exp 1/0", full0, ovf0); end
            checks++; if (rd_data0 !== exp || rd_valid0 !== 1'b1) begin errors++; $display("FAIL rdwr_data got %h exp %h", rd_data0, exp); end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = q.pop_front();
            cycle();
            checks++; if (rd_data0 !== exp) begin errors++; $display("FAIL rdwr_drain got %h exp %h", rd_data0, exp); end
        end
        rd_en = 1'b0;
        cycle();
        checks++; if (empty0 !== 1'b1 || unf0 !== 1'b0) begin errors++; $display("FAIL rdwr_end got empty=%b unf=%b exp 1/0", empty0, unf0); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        cycle();
        checks++; if (unf0 !== 1'b1 || count0 !== 5'd0 || rd_valid0 !== 1'b0) begin errors++; $display("FAIL unf_pulse got %b/%0d/%b exp 1/0/0", unf0, count0, rd_valid0); end
        rd_en = 1'b0;
        cycle();
        checks++; if (unf0 !== 1'b0) begin errors++; $display("FAIL unf_one_cycle got %b exp 0", unf0); end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h3C;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (unf0 !== 1'b1 || count0 !== 5'd1) begin errors++; $display("FAIL unf_empty_rdwr got %b/%0d exp 1/1", unf0, count0); end
        checks++; if (rd_data1 !== 8'h3C || rd_valid1 !== 1'b1) begin errors++; $display("FAIL fwft_3c got %h/%b exp 3c/1", rd_data1, rd_valid1); end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        checks++; if (rd_data0 !== 8'h3C || empty0 !== 1'b1 || rd_valid1 !== 1'b0) begin errors++; $display("FAIL unf_readback got %h/%b/%b exp 3c/1/0", rd_data0, empty0, rd_valid1); end
    endtask

    task automatic test_thresholds();
        logic exp_af, exp_ae;
        afull_thresh = 5'd0;
        #1;
        checks++; if (afull0 !== 1'b1) begin errors++; $display("FAIL thr_zero_afull got %b exp 1", afull0); end
        afull_thresh = 5'd12; aempty_thresh = 5'd3;
        cycle();
        for (int k = 1; k <= 16; k++) begin
            wr_en = 1'b1; wr_data = 8'(k);
            cycle();
            exp_af = (k >= 12);
            exp_ae = (k <= 3);
            checks++; if (afull0 !== exp_af || aempty0 !== exp_ae) begin errors++; $display("FAIL thr_fill count=%0d got af=%b ae=%b exp %b/%b", k, afull0, aempty0, exp_af, exp_ae); end
        end
        wr_en = 1'b0;
        for (int k = 15; k >= 0; k--) begin
            rd_en = 1'b1;
            cycle();
            exp_af = (k >= 12);
            exp_ae = (k <= 3);
            checks++; if (afull0 !== exp_af || aempty0 !== exp_ae || count0 !== 5'(k)) begin errors++; $display("FAIL thr_drain count=%0d got af=%b ae=%b n=%0d exp %b/%b", k, afull0, aempty0, count0, exp_af, exp_ae); end
        end
        rd_en = 1'b0;
        cycle();
    endtask

    task automatic test_parity();
`ifdef SYNC_FIFO_PARITY_EN
        wr_en = 1'b1; wr_data = 8'h55; err_inject = 1'b1;
        cycle();
        wr_data = 8'h66; err_inject = 1'b0;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        checks++; if (rd_data0 !== 8'h55 || perr0 !== 1'b1) begin errors++; $display("FAIL parity_bad got %h/%b exp 55/1", rd_data0, perr0); end
        cycle();
        rd_en = 1'b0;
        checks++; if (rd_data0 !== 8'h66 || perr0 !== 1'b0) begin errors++; $display("FAIL parity_good got %h/%b exp 66/0", rd_data0, perr0); end
        cycle();
`endif
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
            cycle();
        end
        checks++; if (count0 !== 5'd5) begin errors++; $display("FAIL midrst_prefill got %0d exp 5", count0); end
        rst_n = 1'b0;
        cycle();
        checks++; if (count0 !== 5'd0 || empty0 !== 1'b1 || count1 !== 5'd0) begin errors++; $display("FAIL midrst_clear got %0d/%b exp 0/1", count0, empty0); end
        wr_en = 1'b0; rst_n = 1'b1;
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        checks++; if (unf0 !== 1'b1 || rd_valid0 !== 1'b0) begin errors++; $display("FAIL midrst_discard got unf=%b v=%b exp 1/0", unf0, rd_valid0); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_inject = 1'b0;
        afull_thresh = 5'd12; aempty_thresh = 5'd3;
        test_reset();
        test_basic_rw();
        test_overflow();
        test_full_rdwr();
        test_underflow();
        test_thresholds();
        test_parity();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
